ds_addr_seq: RTL and testbench
==============================

DS_ADDR_SEQ -- requirements
Module: ds_addr_seq

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 18, address width; IMG_W, default 256, source width in pixels (even, >=2); IMG_H, default 256, source height (even, >=2); SRC_BASE, default 0, source image base address; OUT_BASE, default 65536, output image base address.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle request to begin a full-frame 2x2 down-sample pass.
REQ-005 abort  in  1  synchronous cancel of a running pass.
REQ-006 mem_ack  in  1  memory completes the current transfer this cycle (read data valid same cycle).
REQ-007 mem_req  out  1  transfer request, held until acknowledged.
REQ-008 mem_we  out  1  1 = write transfer, 0 = read; valid while mem_req=1.
REQ-009 mem_addr  out  ADDR_W  transfer address; valid while mem_req=1.
REQ-010 acc_clr  out  1  clear the external pixel accumulator.
REQ-011 acc_en  out  1  add the current read data to the accumulator.
REQ-012 pix_idx  out  2  index 0..3 of the pixel being read within the 2x2 block.
REQ-013 busy  out  1  pass in progress.
REQ-014 done  out  1  one-cycle pulse when the final output pixel write is acknowledged.

Function
REQ-015 States SHALL be IDLE, RD, WR; RD covers pix_idx 0..3.
REQ-016 IDLE: start=1 SHALL zero the row/col counters, set the output pointer to OUT_BASE, and move to RD with pix_idx=0; acc_clr SHALL pulse that same cycle.
REQ-017 Block base address SHALL be SRC_BASE + row*IMG_W + col; pix_idx 0,1,2,3 SHALL address base, base+1, base+IMG_W, base+IMG_W+1.
REQ-018 A transfer SHALL complete only on a cycle with mem_req=1 and mem_ack=1; mem_addr and mem_we SHALL remain stable from assertion until that cycle.
REQ-019 In RD, acc_en SHALL equal mem_req AND mem_ack; on completion pix_idx SHALL increment, and after pix_idx=3 the state SHALL move to WR.
REQ-020 WR SHALL assert mem_req=1 and mem_we=1 with mem_addr = output pointer; on completion the pointer SHALL increment by 1.
REQ-021 After WR completes: col SHALL advance by 2; col=IMG_W-2 SHALL wrap col to 0 and advance row by 2.
REQ-022 After WR completes, if the block was not the last, the next state SHALL be RD with pix_idx=0 and acc_clr pulsed in the same cycle.
REQ-023 The last block is row=IMG_H-2 and col=IMG_W-2; its WR completion SHALL pulse done and return to IDLE.
REQ-024 With mem_ack tied to 1, each output pixel SHALL take exactly 5 cycles, and a pass SHALL take (IMG_W/2)*(IMG_H/2)*5 cycles.
REQ-025 busy SHALL be 1 in RD and WR and 0 in IDLE; start SHALL be ignored while busy=1.
REQ-026 abort=1 in RD/WR SHALL return to IDLE next cycle: no done, mem_req deasserted, counters retained but cleared by the next start.
REQ-027 abort and mem_ack together SHALL give abort priority: the transfer is not counted and acc_en=0.
REQ-028 All address arithmetic SHALL be ADDR_W-bit modulo 2^ADDR_W; overflow SHALL not be flagged.

Reset
REQ-029 rst=1 SHALL force IDLE, row=col=0, pix_idx=0, output pointer=OUT_BASE, and drive mem_req, mem_we, acc_clr, acc_en, busy, done and mem_addr to 0.
REQ-030 rst SHALL override start, abort and mem_ack, including in the middle of a pass.

Structure
REQ-031 The state encoding, ADDR_W and pix_idx width SHALL reside in shared package ds_pkg.
REQ-032 Row/col stepping SHALL be a sub-module ds_pos_cnt (step 2, wrap, last-block flag); the FSM and address calculation SHALL stay in ds_addr_seq.

Verification (bench IMG_W=4, IMG_H=4, SRC_BASE=0, OUT_BASE=100)
REQ-033 rst held 2 cycles -> all outputs 0, busy=0.
REQ-034 start, mem_ack=1 -> reads 0,1,4,5 then write 100; reads 2,3,6,7 then write 101; reads 8,9,12,13 then write 102; reads 10,11,14,15 then write 103; done on cycle 20.
REQ-035 mem_ack delayed 3 cycles per transfer -> mem_req/mem_addr stable throughout, acc_en exactly 4 pulses per block.
REQ-036 start reasserted mid-pass -> ignored, address sequence unchanged.
REQ-037 abort during the read of address 6 -> IDLE next cycle, no done; new start -> first read address 0, first write 100.
REQ-038 rst during the WR of 102 -> outputs 0 next cycle; new start reproduces the full REQ-034 sequence.

Source files
------------

// File: rtl/ds_pkg.sv
// ds_pkg: shared definitions for the 2x2 down-sample address sequencer.
//   DS_ADDR_W : default address width
//   DS_PIX_W  : width of the pixel-within-block index
//   ds_state_e: sequencer state encoding
package ds_pkg;

  localparam int unsigned DS_ADDR_W = 18;
  localparam int unsigned DS_PIX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } ds_state_e;

endpackage

// File: rtl/ds_pos_cnt.sv
// ds_pos_cnt: block position counter for the 2x2 down-sampler.
// Steps col by 2 across a row, wraps col and steps row by 2 at the row end,
// and flags the last block of the frame.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : return to block (0,0)
//   step_i   : advance to the next block
//   row_o    : current block row (top pixel row)
//   col_o    : current block column (left pixel column)
//   last_o   : current block is the final one of the frame
module ds_pos_cnt #(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256,
  parameter int unsigned ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1,
  parameter int unsigned COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             step_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 2);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (step_i) begin
      if (last_o) begin
        row_q <= '0;
        col_q <= '0;
      end else if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(2);
      end else begin
        col_q <= col_q + COL_W'(2);
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/ds_addr_seq.sv
// ds_addr_seq: address sequencer for a full-frame 2x2 down-sample pass.
// For each 2x2 source block it issues four reads (feeding an external
// accumulator) followed by one write of the result to the output image.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a pass (ignored while busy)
//   abort     : cancel a running pass
//   mem_ack   : current transfer completes this cycle
//   mem_req   : transfer request, mem_we selects write, mem_addr address
//   acc_clr   : clear accumulator, acc_en accumulate read data
//   pix_idx   : pixel index 0..3 within the current block
//   busy      : pass in progress, done pulses on the final write ack
module ds_addr_seq
  import ds_pkg::*;
#(
  parameter int unsigned ADDR_W   = DS_ADDR_W,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned OUT_BASE = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                acc_clr,
  output logic                acc_en,
  output logic [DS_PIX_W-1:0] pix_idx,
  output logic                busy,
  output logic                done
);

  localparam int unsigned ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;

  ds_state_e             state_q;
  logic [DS_PIX_W-1:0]   pix_q;
  logic [ADDR_W-1:0]     out_ptr_q;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic                  last_blk;
  logic                  launch;
  logic                  rd_done;
  logic                  wr_done;
  logic [ADDR_W-1:0]     blk_base;
  logic [ADDR_W-1:0]     rd_addr;

  // abort outranks mem_ack: an aborted transfer never counts
  assign launch  = (state_q == ST_IDLE) && start;
  assign rd_done = (state_q == ST_RD) && mem_ack && !abort;
  assign wr_done = (state_q == ST_WR) && mem_ack && !abort;

  ds_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (launch),
    .step_i (wr_done),
    .row_o  (row),
    .col_o  (col),
    .last_o (last_blk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pix_q     <= '0;
      out_ptr_q <= ADDR_W'(OUT_BASE);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_RD;
            pix_q     <= '0;
            out_ptr_q <= ADDR_W'(OUT_BASE);
          end
        end
        ST_RD: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (mem_ack) begin
            // pix_q wraps 3 -> 0, ready for the next block
            pix_q <= pix_q + 1'b1;
            if (pix_q == '1) state_q <= ST_WR;
          end
        end
        ST_WR: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (mem_ack) begin
            out_ptr_q <= out_ptr_q + 1'b1;
            state_q   <= last_blk ? ST_IDLE : ST_RD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Address arithmetic is modulo 2^ADDR_W by construction
  always_comb begin
    blk_base = ADDR_W'(SRC_BASE) + ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    rd_addr  = blk_base;
    if (pix_q[0]) rd_addr = rd_addr + ADDR_W'(1);
    if (pix_q[1]) rd_addr = rd_addr + ADDR_W'(IMG_W);
  end

  assign busy     = !rst && (state_q != ST_IDLE);
  assign mem_req  = busy;
  assign mem_we   = !rst && (state_q == ST_WR);
  assign mem_addr = (rst || state_q == ST_IDLE) ? '0 :
                    (state_q == ST_WR) ? out_ptr_q : rd_addr;
  assign acc_en   = !rst && rd_done;
  assign acc_clr  = !rst && (launch || (wr_done && !last_blk));
  assign done     = !rst && wr_done && last_blk;
  assign pix_idx  = pix_q;

endmodule

// File: tb/tb_ds_addr_seq.sv
module tb_ds_addr_seq;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned SRC  = 0;
  localparam int unsigned OUTB = 100;
  localparam int          BUDGET = 400;

  logic        clk = 1'b0;
  logic        rst, start, abort, mem_ack;
  logic        mem_req, mem_we, acc_clr, acc_en, busy, done;
  logic [17:0] mem_addr;
  logic [1:0]  pix_idx;

  int checks   = 0;
  int failures = 0;

  ds_addr_seq #(
    .ADDR_W   (18),
    .IMG_W    (W),
    .IMG_H    (H),
    .SRC_BASE (SRC),
    .OUT_BASE (OUTB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .pix_idx  (pix_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_mem_req"}, 32'(mem_req), 0);
    check({pfx, "_mem_we"},  32'(mem_we), 0);
    check({pfx, "_addr"},    32'(mem_addr), 0);
    check({pfx, "_acc_clr"}, 32'(acc_clr), 0);
    check({pfx, "_acc_en"},  32'(acc_en), 0);
    check({pfx, "_busy"},    32'(busy), 0);
    check({pfx, "_done"},    32'(done), 0);
  endtask

  // One pass against a reference transfer list derived from the frame geometry.
  // wait_max: ack delay per transfer (fixed, or random 0..wait_max when rnd=1).
  // abort_addr / rst_widx: inject abort on that read address / reset on that write.
  task automatic run_pass(input int wait_max, input bit rnd, input bit mid_start,
                          input int abort_addr, input int rst_widx);
    int unsigned ea[$];
    bit          ew[$];
    int          k = 0;
    int          idx = 0;
    int          wcnt;
    int          cyc;
    int          acc_cnt = 0;
    int          len;
    for (int r = 0; r < int'(H); r += 2) begin
      for (int c = 0; c < int'(W); c += 2) begin
        int unsigned b;
        b = SRC + r * W + c;
        ea.push_back(b);         ew.push_back(1'b0);
        ea.push_back(b + 1);     ew.push_back(1'b0);
        ea.push_back(b + W);     ew.push_back(1'b0);
        ea.push_back(b + W + 1); ew.push_back(1'b0);
        ea.push_back(OUTB + k);  ew.push_back(1'b1);
        k++;
      end
    end
    len = ea.size();

    @(negedge clk);
    start = 1'b1; mem_ack = 1'b0; abort = 1'b0;
    #1;
    check("start_acc_clr", 32'(acc_clr), 1);
    check("start_idle_req", 32'(mem_req), 0);
    @(negedge clk);
    start = 1'b0;
    cyc  = 1;
    wcnt = rnd ? int'($urandom_range(0, wait_max)) : wait_max;

    while (idx < len && cyc <= BUDGET) begin
      if (abort_addr >= 0 && !ew[idx] && ea[idx] == abort_addr) begin
        abort = 1'b1; mem_ack = 1'b1;
        #1;
        check("abort_acc_en", 32'(acc_en), 0);
        check("abort_done", 32'(done), 0);
        check("abort_addr", 32'(mem_addr), ea[idx]);
        @(negedge clk);
        abort = 1'b0; mem_ack = 1'b0;
        #1;
        check_quiet("post_abort");
        return;
      end
      if (rst_widx >= 0 && ew[idx] && ea[idx] == OUTB + rst_widx) begin
        check("pre_rst_addr", 32'(mem_addr), ea[idx]);
        rst = 1'b1; mem_ack = 1'b1;
        #1;
        check_quiet("in_rst");
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0;
        #1;
        check_quiet("post_rst");
        return;
      end

      mem_ack = (wcnt == 0);
      start   = mid_start && (cyc == 7);
      #1;
      check("busy", 32'(busy), 1);
      check("mem_req", 32'(mem_req), 1);
      check("mem_we", 32'(mem_we), 32'(ew[idx]));
      check("mem_addr", 32'(mem_addr), ea[idx]);
      if (!ew[idx]) check("pix_idx", 32'(pix_idx), idx % 5);
      if (mem_ack) begin
        check("acc_en", 32'(acc_en), 32'(!ew[idx]));
        check("done", 32'(done), 32'(idx == len - 1));
        check("acc_clr", 32'(acc_clr), 32'(ew[idx] && idx != len - 1));
        if (ew[idx]) begin
          check("acc_pulses", acc_cnt, 4);
          acc_cnt = 0;
        end else begin
          acc_cnt++;
        end
        if (idx == len - 1 && !rnd && wait_max == 0)
          check("done_cycle", cyc, (W / 2) * (H / 2) * 5);
        idx++;
        wcnt = rnd ? int'($urandom_range(0, wait_max)) : wait_max;
      end else begin
        check("acc_en_wait", 32'(acc_en), 0);
        check("done_wait", 32'(done), 0);
        check("acc_clr_wait", 32'(acc_clr), 0);
        wcnt--;
      end
      @(negedge clk);
      mem_ack = 1'b0; start = 1'b0;
      cyc++;
    end

    check("pass_complete", idx, len);
    #1;
    check_quiet("after_pass");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_pix", 32'(pix_idx), 0);
    rst = 1'b0;

    run_pass(0, 1'b0, 1'b0, -1, -1);   // back-to-back acks, 20-cycle pass
    run_pass(3, 1'b0, 1'b0, -1, -1);   // every transfer delayed 3 cycles
    run_pass(3, 1'b1, 1'b1, -1, -1);   // random delays, start reissued mid-pass
    run_pass(2, 1'b1, 1'b0, 6, -1);    // abort while reading address 6
    run_pass(0, 1'b0, 1'b0, -1, -1);
    run_pass(1, 1'b1, 1'b0, -1, 2);    // reset during write of 102
    run_pass(0, 1'b0, 1'b0, -1, -1);
    run_pass(3, 1'b1, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
